// File: rtl/signed_frame_minmax_if.sv
// Stream bundle for signed_frame_minmax: sample input and per-frame result output.
// SFMM_INDEX_EN adds the min/max position signals.
interface signed_frame_minmax_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
`ifdef SFMM_INDEX_EN
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_max_idx;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count, out_min_idx, out_max_idx
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );
`endif
endinterface

// File: rtl/signed_frame_minmax.sv
// Per-frame signed min/max/count over a valid/ready sample stream.
// Define SFMM_INDEX_EN to also track the positions of the extremes.
module signed_frame_minmax #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  signed_frame_minmax_if.slave bus
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SFMM_INDEX_EN
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

  logic accept;

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
  assign bus.out_count = cnt_q;
`ifdef SFMM_INDEX_EN
  assign bus.out_min_idx = min_idx_q;
  assign bus.out_max_idx = max_idx_q;
`endif

  assign accept = bus.in_valid && (state_q != HOLD);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
`ifdef SFMM_INDEX_EN
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
`endif
    unique case (state_q)
      FIRST: begin
        if (accept) begin
          min_d   = bus.in_data;
          max_d   = bus.in_data;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef SFMM_INDEX_EN
          min_idx_d = '0;
          max_idx_d = '0;
`endif
          state_d = bus.in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // Strict compares: ties keep the earliest occurrence; index is the pre-increment count.
          if (lt(bus.in_data, min_q)) begin
            min_d = bus.in_data;
`ifdef SFMM_INDEX_EN
            min_idx_d = cnt_q;
`endif
          end
          if (lt(max_q, bus.in_data)) begin
            max_d = bus.in_data;
`ifdef SFMM_INDEX_EN
            max_idx_d = cnt_q;
`endif
          end
          if (cnt_q != '1) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (bus.in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FIRST;
        end
      end
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIRST;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
`ifdef SFMM_INDEX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
`ifdef SFMM_INDEX_EN
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
`endif
    end
  end

endmodule

// File: doc/signed_frame_minmax.md
# signed_frame_minmax

Streaming consumer of signed 32-bit less-than decisions: accepts framed two's-complement samples over a valid/ready handshake and reports, per frame, the minimum, the maximum and the sample count. It sits directly downstream of the 32-bit signed less-than comparator. It registers the running extremes and repeatedly feeds them, together with each new sample, through the signed-lt function. Results are handed to the next stage over a second valid/ready handshake.

## Interface
- `WIDTH`, default 32: sample width, two's complement.
- `CNT_W`, default 16: width of the frame counter and of the index outputs.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `in_valid` input, 1 bit: a sample is offered.
- `in_ready` output, 1 bit: the block can accept a sample.
- `in_data` input, WIDTH bits: signed sample.
- `in_last` input, 1 bit: the offered sample closes the frame.
- `out_valid` output, 1 bit: a frame result is held.
- `out_ready` input, 1 bit: the downstream stage accepts the result.
- `out_min` output, WIDTH bits: signed minimum of the frame.
- `out_max` output, WIDTH bits: signed maximum of the frame.
- `out_count` output, CNT_W bits: number of samples in the frame, saturating.
- `out_min_idx` output, CNT_W bits: position of the minimum; present only with `SFMM_INDEX_EN`.
- `out_max_idx` output, CNT_W bits: position of the maximum; present only with `SFMM_INDEX_EN`.

## Operation
- A sample is accepted on any cycle where `in_valid && in_ready` are both high.
- States:
  - `FIRST`: waiting for the first sample of a frame.
  - `ACC`: accumulating samples within a frame.
  - `HOLD`: a frame result is presented.
- `in_ready` = 1 in `FIRST` and `ACC`; 0 in `HOLD`.
- Sample accepted in `FIRST`:
  - cur_min = cur_max = in_data; cnt = 1; both indices = 0.
  - Go to `HOLD` if `in_last`, else to `ACC`.
- Sample accepted in `ACC`, with lt(a,b) the signed two's-complement a < b:
  - If lt(in_data, cur_min): cur_min = in_data, min_idx = cnt.
  - If lt(cur_max, in_data): cur_max = in_data, max_idx = cnt.
  - cnt = cnt + 1, saturating at 2^CNT_W−1. The index recorded is the pre-increment cnt, so it saturates as well.
  - If `in_last`: go to `HOLD`.
- Ties never update an extreme, so the earliest occurrence wins for both min and max.
- `HOLD`:
  - Outputs present the final registers and `out_valid` = 1.
  - On `out_valid && out_ready`: go to `FIRST` and clear `out_valid`.
- An `in_last` sample taken in `FIRST` produces a one-sample frame: min = max = sample, count 1, indices 0.
- Signed extremes are ordered correctly: 0x80000000 is below every other value, 0x7FFFFFFF is above every other value. −1 (0xFFFFFFFF) is below 0.
- Reset (`rst_n` = 0 at a clock edge) has priority over everything:
  - state = `FIRST`; all registers and outputs = 0; `out_valid` = 0; `in_ready` = 1 from the first cycle after reset.
  - A frame in progress is discarded and no partial result is ever emitted.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_min` = `out_max` = `out_count` = `out_min_idx` = `out_max_idx` = 0.
- Accumulation throughput: one sample per cycle.
- Latency: `out_valid` rises on the cycle after the `in_last` sample is accepted, and the result includes that sample.
- While `out_valid && !out_ready`, all out_* signals are held stable.
- After the output handshake, `in_ready` is 1 on the next cycle. This gives exactly one bubble between frames when `out_ready` is held high.
- `in_ready` depends only on registered state, never combinationally on `out_ready`.
- The comparison path is combinational from `in_data` to the next-state registers, one signed-lt per extreme per cycle.

## Configuration
- `SFMM_INDEX_EN` defined:
  - `out_min_idx` / `out_max_idx` ports and their registers exist, with the tie rule above.
- `SFMM_INDEX_EN` undefined:
  - The ports and their registers are absent.
  - min, max and count behaviour and all timing are identical.

## Test plan
- Frame {5, −3, 7, −3, 7(last)} with `out_ready` = 1:
  - `out_min` = 0xFFFFFFFD, `out_max` = 7, count 5, min_idx 1, max_idx 2.
  - `out_valid` high for one cycle, one cycle after the last sample.
- Frame {0x7FFFFFFF, 0x80000000, 0, 0xFFFFFFFF(last)}:
  - min 0x80000000 (idx 1), max 0x7FFFFFFF (idx 0), count 4.
- Single sample 0xFFFFFFFF with `in_last`:
  - min = max = 0xFFFFFFFF, count 1, indices 0.
- Backpressure, `out_ready` = 0 for 5 cycles after a result:
  - Outputs stay stable and `in_ready` stays 0 while `in_valid` is held high.
  - Next frame {1, 2(last)} yields min 1, max 2 only after the handshake.
- `rst_n` pulsed low after 3 samples of a frame:
  - All outputs 0 and `in_ready` 1 after reset.
  - Following frame {9(last)} yields min = max = 9, count 1.
- With CNT_W = 4, a 20-sample frame with the minimum −8 at position 18:
  - count = 15, min_idx = 15 (saturated), max correct.
